// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light controller: phase encoding, lamp indices
// and the duration range check used at elaboration.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'b00,
    GREEN   = 2'b01,
    YELLOW  = 2'b10,
    NIGHT   = 2'b11
  } state_t;

  localparam int LAMP_RED    = 0;
  localparam int LAMP_YELLOW = 1;
  localparam int LAMP_GREEN  = 2;
  localparam int LAMP_N      = 3;

  typedef logic [LAMP_N-1:0] lamp_t;

  function automatic bit dur_ok(input int t, input int cnt_w);
    return (t >= 1) && (t <= (1 << cnt_w));
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Time-base/control inputs and lamp/countdown outputs of the controller.
// master = tick source and lamp drivers, slave = the controller itself.
interface traffic_light_ctrl_if #(
  parameter int N_DIR = 2,
  parameter int CNT_W = 6
);
  localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  logic             tick;
  logic             en;
  logic             night;
  logic [N_DIR-1:0] red;
  logic [N_DIR-1:0] yellow;
  logic [N_DIR-1:0] green;
  logic [DIR_W-1:0] active_dir;
  logic [CNT_W-1:0] remaining;

  modport master (
    output tick, en, night,
    input  red, yellow, green, active_dir, remaining
  );

  modport slave (
    input  tick, en, night,
    output red, yellow, green, active_dir, remaining
  );

endinterface

// File: rtl/lamp_decode.sv
// Combinational lamp decoder: phase, owning direction and blink phase to
// per-direction red/yellow/green vectors.
module lamp_decode
  import traffic_pkg::*;
#(
  parameter int N_DIR = 2,
  parameter int DIR_W = 1
) (
  input  state_t           state,
  input  logic [DIR_W-1:0] active_dir,
  input  logic             blink,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green
);

  lamp_t [N_DIR-1:0] lamp;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lamp   = '0;
    red    = '0;
    yellow = '0;
    green  = '0;
    for (int i = 0; i < N_DIR; i++) begin
      lamp[i][LAMP_GREEN]  = (state == GREEN) && (active_dir == DIR_W'(i));
      lamp[i][LAMP_YELLOW] = ((state == YELLOW) && (active_dir == DIR_W'(i))) ||
                             ((state == NIGHT) && blink);
      // Night mode darkens red on every approach.
      lamp[i][LAMP_RED]    = (state != NIGHT) && !lamp[i][LAMP_GREEN] && !lamp[i][LAMP_YELLOW];
      red[i]    = lamp[i][LAMP_RED];
      yellow[i] = lamp[i][LAMP_YELLOW];
      green[i]  = lamp[i][LAMP_GREEN];
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin multi-approach traffic-light sequencer (ALL_RED -> GREEN -> YELLOW).
// Optional flashing-yellow night mode is built when TRAFFIC_NIGHT_EN is defined.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR    = 2,
  parameter int CNT_W    = 6,
  parameter int T_GREEN  = 25,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  traffic_light_ctrl_if.slave bus
);

  localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  localparam logic [CNT_W-1:0] LOAD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LOAD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LOAD_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [DIR_W-1:0] LAST_DIR    = DIR_W'(N_DIR - 1);

  if (N_DIR < 2 || N_DIR > 4) begin : g_bad_ndir
    $error("traffic_light_ctrl: N_DIR must be 2..4");
  end
  if (!dur_ok(T_GREEN, CNT_W) || !dur_ok(T_YELLOW, CNT_W) || !dur_ok(T_ALLRED, CNT_W)) begin : g_bad_dur
    $error("traffic_light_ctrl: each T_* must be in 1..2**CNT_W");
  end

  state_t           state_q, state_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             advance;

`ifdef TRAFFIC_NIGHT_EN
  logic blink_q, blink_d;
`else
  logic blink_q;
  logic unused_night;
  assign blink_q      = 1'b0;
  assign unused_night = bus.night;
`endif

  assign advance = bus.en && bus.tick;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
`ifdef TRAFFIC_NIGHT_EN
    blink_d = blink_q;
`endif
    if (advance) begin
      case (state_q)
        ALL_RED: begin
          if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
`ifdef TRAFFIC_NIGHT_EN
          end else if (bus.night) begin
            state_d = NIGHT;
            rem_d   = '0;
`endif
          end else begin
            state_d = GREEN;
            rem_d   = LOAD_GREEN;
          end
        end
        GREEN: begin
          if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
          end else begin
            state_d = YELLOW;
            rem_d   = LOAD_YELLOW;
          end
        end
        YELLOW: begin
          if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
          end else begin
            state_d = ALL_RED;
            dir_d   = (dir_q == LAST_DIR) ? '0 : dir_q + 1'b1;
            rem_d   = LOAD_ALLRED;
          end
        end
`ifdef TRAFFIC_NIGHT_EN
        NIGHT: begin
          // Leaving night wins over the blink toggle on the same tick.
          if (!bus.night) begin
            state_d = ALL_RED;
            dir_d   = '0;
            rem_d   = LOAD_ALLRED;
            blink_d = 1'b0;
          end else begin
            blink_d = !blink_q;
          end
        end
`endif
        default: begin
          state_d = ALL_RED;
          dir_d   = '0;
          rem_d   = LOAD_ALLRED;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ALL_RED;
      dir_q   <= '0;
      rem_q   <= LOAD_ALLRED;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
    end
  end

`ifdef TRAFFIC_NIGHT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) blink_q <= 1'b0;
    else        blink_q <= blink_d;
  end
`endif

  lamp_decode #(
    .N_DIR (N_DIR),
    .DIR_W (DIR_W)
  ) u_lamp_decode (
    .state      (state_q),
    .active_dir (dir_q),
    .blink      (blink_q),
    .red        (bus.red),
    .yellow     (bus.yellow),
    .green      (bus.green)
  );

  assign bus.active_dir = dir_q;
  assign bus.remaining  = rem_q;

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised multi-direction traffic-light controller, the next generation after the single-lamp state decoder. It sequences N_DIR approaches round-robin through green, yellow and all-red phases with per-phase tick-counted durations. It drives per-direction one-hot lamp outputs and a countdown value for the display board. It sits between the 1 Hz tick generator and the lamp/7-segment drivers.

## Interface
- N_DIR, 2: number of approaches served round-robin (2..4).
- CNT_W, 6: countdown width; every duration must satisfy 1 ≤ T ≤ 2^CNT_W.
- T_GREEN, 25: green phase length in ticks.
- T_YELLOW, 3: yellow phase length in ticks.
- T_ALLRED, 2: all-red clearance length in ticks.

- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; synchronous, active-low.
- tick  in  1  single-cycle time-base strobe (nominally 1 Hz).
- en  in  1  run enable; 0 freezes counter, state and blink phase.
- night  in  1  night-mode request (flashing yellow); see Configuration.
- red  out  N_DIR  red lamp per direction.
- yellow  out  N_DIR  yellow lamp per direction.
- green  out  N_DIR  green lamp per direction.
- active_dir  out  $clog2(N_DIR)  direction currently owning green/yellow.
- remaining  out  CNT_W  ticks left in current phase, minus one.

## Operation
- States: ALL_RED, GREEN, YELLOW, NIGHT (NIGHT only with macro).
- Reset: state=ALL_RED, active_dir=0, remaining=T_ALLRED-1, red=all 1, yellow=0, green=0, blink=0.
- Phase advance happens only on a cycle with en=1 and tick=1. If remaining≠0, decrement. If remaining=0, transition and load next duration-1.
- ALL_RED→GREEN, same active_dir, load T_GREEN-1.
- GREEN→YELLOW, load T_YELLOW-1.
- YELLOW→ALL_RED, active_dir←(active_dir+1) mod N_DIR (wraps N_DIR-1→0), load T_ALLRED-1.
- Lamps, direction i: green[i]=(GREEN && active_dir==i); yellow[i]=(YELLOW && active_dir==i); red[i]=!green[i]&&!yellow[i]. At most one non-red direction at any time.
- Night entry: sampled only at ALL_RED expiry (tick with remaining=0). If night=1 then, go to NIGHT instead of GREEN. Night is never entered mid-green or mid-yellow.
- NIGHT: red=0, green=0, yellow=all blink. blink toggles on each enabled tick. remaining holds 0.
- Night exit: on an enabled tick with night=0, go to ALL_RED with active_dir=0, remaining=T_ALLRED-1, blink=0.
- en=0: every register holds. tick is ignored; it is not queued.
- rst_n=0 mid-phase: reset values on the next edge, regardless of tick/en.

## Timing
- All state, counter, active_dir and blink are registered. Lamp outputs are decoded from registered state and change on the same edge as the state transition. There is no added output latency.
- With tick every cycle, the full cycle is N_DIR·(T_GREEN+T_YELLOW+T_ALLRED) ticks. A phase of length T occupies exactly T ticks.
- After reset deassertion, the first GREEN (dir 0) starts on the T_ALLRED-th enabled tick.
- night change with no tick has no effect. Night exit takes priority over the blink toggle on the same tick.

## Configuration
- TRAFFIC_NIGHT_EN defined: NIGHT state and blink register are present; behaviour as above.
- Undefined: night port is present but ignored. The state machine never leaves the three-phase loop. The yellow lamp is driven only by YELLOW.

## Structure
- Shared package traffic_pkg: the state enum (ALL_RED=2'b00, GREEN=2'b01, YELLOW=2'b10, NIGHT=2'b11) and the lamp index constants used by display/top-level.
- One sub-module: lamp_decode (state, active_dir, blink → red/yellow/green vectors). It is combinational and is the parametrised generalisation of the existing single-lamp decoder.
- Elaboration-time check: each T_* is in range 1..2^CNT_W.

## Test plan
- Reset: N_DIR=2, T_GREEN=5, T_YELLOW=2, T_ALLRED=1, tick every cycle → red=2'b11, remaining=0. Next tick gives green=2'b01, remaining=4.
- Full rotation, same parameters → dir0 green 5 ticks, yellow 2, all-red 1, then green=2'b10, active_dir=1. Wrap to dir0 after 16 ticks. Never two non-red directions.
- en=0 for 10 cycles during GREEN with remaining=3 → outputs and remaining frozen at 3. They resume decrementing when en=1.
- Night (macro on): assert night during GREEN → green/yellow finish normally. Entry happens at ALL_RED expiry, then yellow=2'b11/2'b00 alternate per tick. Deassert → ALL_RED, active_dir=0, remaining=T_ALLRED-1.
- Macro off: night=1 throughout → sequence identical to the rotation test.
- Sync reset mid-YELLOW with active_dir=1 → next edge red=all 1, active_dir=0, remaining=T_ALLRED-1.
